// File: rtl/riscv_dmem_responder.sv
// rtl/riscv_dmem_responder.sv - single-outstanding data-memory responder with fixed response latency
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned halfword/word accesses as errors.
module riscv_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [30:0] DEPTH_L  = 31'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [AW+1:0]   addr_q;
  logic [2:0]      func3_q;
  logic            err_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic            acc_err;
  logic [3:0]      be;
  logic [31:0]     wbus;
  logic [AW-1:0]   widx;

  logic [AW+1:0]   ld_addr;
  logic [2:0]      ld_f3;
  logic            ld_we;
  logic            ld_err;
  logic [31:0]     ld_word;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_data;

  assign req_ready = (state_q == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    acc_err = ({1'b0, req_addr[31:2]} >= DEPTH_L);
    case (req_func3)
      3'b000, 3'b001, 3'b010: ;
      3'b100, 3'b101: if (req_we) acc_err = 1'b1;
      default: acc_err = 1'b1;
    endcase
`ifdef DMEM_MISALIGN_CHECK_EN
    if (req_func3[1:0] == 2'b01 && req_addr[0]) acc_err = 1'b1;
    if (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) acc_err = 1'b1;
`endif
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be   = 4'b1111;
    wbus = req_wdata;
    case (req_func3[1:0])
      2'b00: begin
        be   = 4'b0001 << req_addr[1:0];
        wbus = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be   = req_addr[1] ? 4'b1100 : 4'b0011;
        wbus = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign widx = req_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (accept && req_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wbus[8*b +: 8];
      end
    end
  end

  // With zero latency RESP is entered on the acceptance edge, so load from the live request.
  always_comb begin
    ld_addr = (state_q == IDLE) ? req_addr[AW+1:0] : addr_q;
    ld_f3   = (state_q == IDLE) ? req_func3 : func3_q;
    ld_we   = (state_q == IDLE) ? req_we : we_q;
    ld_err  = (state_q == IDLE) ? acc_err : err_q;
    ld_word = mem[ld_addr[AW+1:2]];
    ld_byte = ld_word[{ld_addr[1:0], 3'b000} +: 8];
    ld_half = ld_addr[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
    if (ld_we || ld_err) ld_data = 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      func3_q     <= 3'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr[AW+1:0];
            func3_q <= req_func3;
            err_q   <= acc_err;
            if (LATENCY > 0) begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= ld_data;
              rsp_err_q   <= acc_err;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ld_data;
            rsp_err_q   <= err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
